// File: rtl/aes_job_arbiter.sv
// Two-channel round-robin job arbiter in front of a pair of AES cipher/decipher cores.
// One job in flight; the response is held until accepted, with a WAIT-state abort timer.

package aes_package;
  parameter int unsigned DATA_WIDTH = 128;
endpackage

module aes_job_arbiter
  import aes_package::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_mode_i,
  input  logic [DATA_WIDTH-1:0] req_data0_i,
  input  logic [DATA_WIDTH-1:0] req_data1_i,
  output logic [DATA_WIDTH-1:0] core_data_o,
  output logic                  enc_start_o,
  output logic                  dec_start_o,
  input  logic [DATA_WIDTH-1:0] enc_result_i,
  input  logic [DATA_WIDTH-1:0] dec_result_i,
  input  logic                  enc_done_i,
  input  logic                  dec_done_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_id_o,
  output logic                  rsp_mode_o,
  output logic                  rsp_timeout_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  id_q, id_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  tout_q, tout_d;
  logic                  rsp_valid_q;

  logic gnt_id;
  logic sel_done;
  logic xfer;

  // On a tie the channel that did not win last time goes next.
  always_comb begin
    if (req_valid_i == 2'b11) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = req_valid_i[1];
    end
  end

  always_comb begin
    req_ready_o = 2'b00;
    if (state_q == StIdle && |req_valid_i) begin
      req_ready_o = gnt_id ? 2'b10 : 2'b01;
    end
  end

  assign xfer     = |(req_valid_i & req_ready_o);
  assign sel_done = mode_q ? dec_done_i : enc_done_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    id_d    = id_q;
    mode_d  = mode_q;
    rdata_d = rdata_q;
    tout_d  = tout_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          data_d  = gnt_id ? req_data1_i : req_data0_i;
          id_d    = gnt_id;
          mode_d  = req_mode_i[gnt_id];
          last_d  = gnt_id;
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done on the last permitted cycle still beats the abort.
        if (sel_done) begin
          rdata_d = mode_q ? dec_result_i : enc_result_i;
          tout_d  = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          tout_d  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      data_q      <= '0;
      id_q        <= 1'b0;
      mode_q      <= 1'b0;
      rdata_q     <= '0;
      tout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      id_q        <= id_d;
      mode_q      <= mode_d;
      rdata_q     <= rdata_d;
      tout_q      <= tout_d;
      rsp_valid_q <= (state_d == StResp);
    end
  end

  assign core_data_o   = data_q;
  assign enc_start_o   = (state_q == StStart) && !mode_q;
  assign dec_start_o   = (state_q == StStart) && mode_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rdata_q;
  assign rsp_id_o      = id_q;
  assign rsp_mode_o    = mode_q;
  assign rsp_timeout_o = tout_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter: a default-timeout instance for the job flows and a
// TIMEOUT_CYCLES=8 instance for the abort path, each held in reset while the other runs.

module tb_aes_job_arbiter;

  logic         clk;
  logic         rst_a, rst_b;
  logic [1:0]   req_valid, req_mode;
  logic [127:0] data0, data1, enc_result, dec_result;
  logic         enc_done, dec_done, rsp_ready;

  logic [1:0]   req_ready, t_req_ready;
  logic [127:0] core_data, t_core_data, rsp_data, t_rsp_data;
  logic         enc_start, dec_start, rsp_valid, rsp_id, rsp_mode, rsp_timeout;
  logic         t_enc_start, t_dec_start, t_rsp_valid, t_rsp_id, t_rsp_mode, t_rsp_timeout;

  int n_tests;
  int n_fail;
  int bad;

  aes_job_arbiter u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_a),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_mode_i   (req_mode),
    .req_data0_i  (data0),
    .req_data1_i  (data1),
    .core_data_o  (core_data),
    .enc_start_o  (enc_start),
    .dec_start_o  (dec_start),
    .enc_result_i (enc_result),
    .dec_result_i (dec_result),
    .enc_done_i   (enc_done),
    .dec_done_i   (dec_done),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_id_o     (rsp_id),
    .rsp_mode_o   (rsp_mode),
    .rsp_timeout_o(rsp_timeout)
  );

  aes_job_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) u_dut_to (
    .clk_i        (clk),
    .rst_ni       (rst_b),
    .req_valid_i  (req_valid),
    .req_ready_o  (t_req_ready),
    .req_mode_i   (req_mode),
    .req_data0_i  (data0),
    .req_data1_i  (data1),
    .core_data_o  (t_core_data),
    .enc_start_o  (t_enc_start),
    .dec_start_o  (t_dec_start),
    .enc_result_i (enc_result),
    .dec_result_i (dec_result),
    .enc_done_i   (enc_done),
    .dec_done_i   (dec_done),
    .rsp_valid_o  (t_rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (t_rsp_data),
    .rsp_id_o     (t_rsp_id),
    .rsp_mode_o   (t_rsp_mode),
    .rsp_timeout_o(t_rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Entered in the IDLE cycle where the transfer is expected; leaves in the IDLE cycle after
  // the response is accepted. The selected done arrives k cycles after the start pulse.
  task automatic job(input string tag, input logic [1:0] exp_rdy, input logic exp_mode,
                     input logic [127:0] exp_data, input int k, input logic [127:0] res,
                     input bit spurious, input int hold);
    int   nbad;
    logic exp_id;
    exp_id = exp_rdy[1];
    nbad   = 0;
    #1;
    check_eq({tag, ".ready"}, 128'(req_ready), 128'(exp_rdy));
    cyc();
    check_eq({tag, ".start"}, 128'({enc_start, dec_start}), 128'({~exp_mode, exp_mode}));
    check_eq({tag, ".core"}, core_data, exp_data);
    enc_result = exp_mode ? ~res : res;
    dec_result = exp_mode ? res : ~res;
    for (int j = 1; j <= k; j++) begin
      cyc();
      enc_done = 1'b0;
      dec_done = 1'b0;
      if (j == k) begin
        if (exp_mode) dec_done = 1'b1;
        else enc_done = 1'b1;
      end else if (spurious && j == 1) begin
        if (exp_mode) enc_done = 1'b1;
        else dec_done = 1'b1;
      end
      #1;
      if (rsp_valid || enc_start || dec_start || req_ready != 2'b00 || core_data !== exp_data)
        nbad++;
    end
    check_eq({tag, ".quiet"}, 128'(nbad), 128'(0));
    cyc();
    enc_done = 1'b0;
    dec_done = 1'b0;
    check_eq({tag, ".rsp_valid"}, 128'(rsp_valid), 128'(1));
    check_eq({tag, ".rsp_data"}, rsp_data, res);
    check_eq({tag, ".rsp_fields"}, 128'({rsp_id, rsp_mode, rsp_timeout}),
             128'({exp_id, exp_mode, 1'b0}));
    if (hold > 0) begin
      nbad = 0;
      for (int j = 0; j < hold; j++) begin
        cyc();
        if (!rsp_valid || rsp_data !== res || rsp_id !== exp_id || rsp_mode !== exp_mode ||
            rsp_timeout !== 1'b0 || req_ready != 2'b00) nbad++;
      end
      check_eq({tag, ".hold"}, 128'(nbad), 128'(0));
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check_eq({tag, ".rsp_done"}, 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    clk        = 1'b0;
    rst_a      = 1'b0;
    rst_b      = 1'b0;
    req_valid  = 2'b00;
    req_mode   = 2'b00;
    data0      = '0;
    data1      = '0;
    enc_result = '0;
    dec_result = '0;
    enc_done   = 1'b0;
    dec_done   = 1'b0;
    rsp_ready  = 1'b0;
    n_tests    = 0;
    n_fail     = 0;

    #1;
    check_eq("reset.ctrl", 128'({rsp_valid, enc_start, dec_start, rsp_timeout, req_ready}),
             128'(0));
    check_eq("reset.data", 128'({rsp_data, core_data, rsp_id, rsp_mode}) , 128'(0));
    cyc();
    cyc();
    rst_a = 1'b1;

    // Single encrypt on channel 0
    req_valid = 2'b01;
    req_mode  = 2'b00;
    data0     = 128'h00112233445566778899aabbccddeeff;
    job("enc", 2'b01, 1'b0, 128'h00112233445566778899aabbccddeeff, 10,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 0);

    // Decrypt on channel 1 with a stray enc_done during WAIT
    req_valid = 2'b10;
    req_mode  = 2'b10;
    data1     = 128'hfedcba98765432100123456789abcdef;
    job("dec", 2'b10, 1'b1, 128'hfedcba98765432100123456789abcdef, 5,
        128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b1, 0);
    req_valid = 2'b00;

    // Contention from reset, then backpressure on the fifth job
    rst_a = 1'b0;
    cyc();
    rst_a     = 1'b1;
    req_valid = 2'b11;
    req_mode  = 2'b00;
    data0     = 128'haaaa0000aaaa0000aaaa0000aaaa0000;
    data1     = 128'h5555111155551111555511115555_1111;
    job("rr0", 2'b01, 1'b0, data0, 3, 128'h1, 1'b0, 0);
    job("rr1", 2'b10, 1'b0, data1, 2, 128'h2, 1'b0, 0);
    job("rr2", 2'b01, 1'b0, data0, 1, 128'h3, 1'b0, 0);
    job("rr3", 2'b10, 1'b0, data1, 4, 128'h4, 1'b0, 0);
    job("bp", 2'b01, 1'b0, data0, 4, 128'hdeadbeef, 1'b0, 20);
    #1;
    check_eq("bp.next_grant", 128'(req_ready), 128'(2'b10));
    req_valid = 2'b00;

    // Reset asserted while waiting on the core
    cyc();
    req_valid = 2'b01;
    data0     = 128'h123456789;
    enc_result = 128'hcafe;
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    rst_a = 1'b0;
    #1;
    check_eq("rstwait.ctrl",
             128'({rsp_valid, enc_start, dec_start, rsp_timeout, rsp_id, rsp_mode, req_ready}),
             128'(0));
    check_eq("rstwait.rsp_data", rsp_data, 128'(0));
    check_eq("rstwait.core_data", core_data, 128'(0));
    cyc();
    rst_a = 1'b1;
    cyc();
    enc_done = 1'b1;
    cyc();
    enc_done = 1'b0;
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      if (rsp_valid || enc_start || dec_start) bad++;
    end
    check_eq("rstwait.no_rsp", 128'(bad), 128'(0));

    // Abort path on the short-timeout instance; second pass delivers done on the last cycle
    rst_a = 1'b0;
    rst_b = 1'b1;
    for (int t = 0; t < 2; t++) begin
      req_valid  = 2'b01;
      req_mode   = 2'b00;
      data0      = 128'h77;
      enc_result = 128'hbeef0000beef;
      #1;
      check_eq("to.ready", 128'(t_req_ready), 128'(2'b01));
      cyc();
      req_valid = 2'b00;
      bad = 0;
      for (int j = 1; j <= 8; j++) begin
        cyc();
        enc_done = (t == 1 && j == 8);
        #1;
        if (t_rsp_valid) bad++;
      end
      check_eq("to.quiet", 128'(bad), 128'(0));
      cyc();
      enc_done = 1'b0;
      check_eq("to.rsp_valid", 128'(t_rsp_valid), 128'(1));
      check_eq("to.timeout", 128'(t_rsp_timeout), (t == 0) ? 128'(1) : 128'(0));
      check_eq("to.rsp_data", t_rsp_data, (t == 0) ? 128'(0) : 128'hbeef0000beef);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
